// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller:
// FSM state encoding, forward selects and control bundle.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_EALU = 2'b01;
  localparam logic [1:0] FWD_MALU = 2'b10;
  localparam logic [1:0] FWD_MMEM = 2'b11;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idexe_en;
    logic idexe_bubble;
    logic exemem_en;
    logic memwb_bubble;
  } pipe_ctl_t;

  localparam pipe_ctl_t CTL_RUN =
    '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam pipe_ctl_t CTL_LU =
    '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam pipe_ctl_t CTL_FRZ =
    '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam pipe_ctl_t CTL_RST =
    '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  // Register 0 is hardwired, so it never matches a producer.
  function automatic logic reg_hit(
    input logic [4:0] dst,
    input logic [4:0] src
  );
    return (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd.sv
// Combinational forwarding select for one ID operand.
// EXE results win over MEM results.
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] ern,
  input  logic       ewreg,
  input  logic       em2reg,
  input  logic [4:0] mrn,
  input  logic       mwreg,
  input  logic       mm2reg,
  output logic [1:0] fwd
);

  logic e_hit;
  logic m_hit;

  assign e_hit = ewreg & ~em2reg & reg_hit(ern, src);
  assign m_hit = mwreg & reg_hit(mrn, src);

  // Pick the youngest non-load producer, then MEM alu/load.
  always_comb begin
    fwd = FWD_RF;
    if (e_hit) begin
      fwd = FWD_EALU;
    end else if (m_hit) begin
      fwd = mm2reg ? FWD_MMEM : FWD_MALU;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller: forwarding, load-use bubbles,
// MEM-stage req/ack sequencing and stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic             use_rs,
  input  logic             use_rt,
  input  logic [4:0]       ern,
  input  logic             ewreg,
  input  logic             em2reg,
  input  logic [4:0]       mrn,
  input  logic             mwreg,
  input  logic             mm2reg,
  input  logic             mwmem,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idexe_en,
  output logic             idexe_bubble,
  output logic             exemem_en,
  output logic             memwb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WC_W = $clog2(TIMEOUT) + 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [WC_W-1:0]  wait_q, wait_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       lu;
  logic       mem_op;
  logic       freeze;
  pipe_ctl_t  ctl;

  fwd_unit u_fwd_a (
    .src    (rs),
    .ern    (ern),
    .ewreg  (ewreg),
    .em2reg (em2reg),
    .mrn    (mrn),
    .mwreg  (mwreg),
    .mm2reg (mm2reg),
    .fwd    (fwd_a)
  );

  fwd_unit u_fwd_b (
    .src    (rt),
    .ern    (ern),
    .ewreg  (ewreg),
    .em2reg (em2reg),
    .mrn    (mrn),
    .mwreg  (mwreg),
    .mm2reg (mm2reg),
    .fwd    (fwd_b)
  );

  assign mem_op = mm2reg | mwmem;

  assign lu = ewreg & em2reg
            & ((use_rs & reg_hit(ern, rs))
            |  (use_rt & reg_hit(ern, rt)));

  // IDLE freezes the cycle a mem op is seen; DONE lets it drain.
  assign freeze = ((state_q == ST_IDLE) & mem_op)
                | (state_q == ST_REQ)
                | (state_q == ST_ERR);

  // Memory access sequencer next-state and timeout tracking.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (mem_op) begin
          state_d = ST_REQ;
          wait_d  = '0;
        end
      end
      ST_REQ: begin
        if (dmem_ack) begin
          state_d = ST_DONE;
          wait_d  = '0;
        end else if (wait_q == WC_LAST) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_ERR;
    endcase
  end

  // Pipeline control: reset, then freeze, then load-use.
  always_comb begin
    ctl = CTL_RUN;
    if (rst) begin
      ctl = CTL_RST;
    end else if (freeze) begin
      ctl = CTL_FRZ;
    end else if (lu) begin
      ctl = CTL_LU;
    end
  end

  // Saturating count of cycles where the PC is held.
  always_comb begin
    cnt_d = cnt_q;
    if (!ctl.pc_en && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State, timeout, error and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dmem_req     = ~rst & (state_q == ST_REQ);
  assign fwda         = rst ? FWD_RF : fwd_a;
  assign fwdb         = rst ? FWD_RF : fwd_b;
  assign pc_en        = ctl.pc_en;
  assign ifid_en      = ctl.ifid_en;
  assign idexe_en     = ctl.idexe_en;
  assign idexe_bubble = ctl.idexe_bubble;
  assign exemem_en    = ctl.exemem_en;
  assign memwb_bubble = ctl.memwb_bubble;
  assign mem_err      = err_q;
  assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed plan
// sequences followed by randomized traffic.
module tb_pipe_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] rs = '0, rt = '0, ern = '0, mrn = '0;
  logic use_rs = 0, use_rt = 0, ewreg = 0, em2reg = 0;
  logic mwreg = 0, mm2reg = 0, mwmem = 0, dmem_ack = 0;
  logic dmem_req, pc_en, ifid_en, idexe_en, idexe_bubble;
  logic exemem_en, memwb_bubble, mem_err;
  logic [1:0] fwda, fwdb;
  logic [CNT_W-1:0] stall_cnt;

  pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt),
    .use_rs(use_rs), .use_rt(use_rt), .ern(ern),
    .ewreg(ewreg), .em2reg(em2reg), .mrn(mrn),
    .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
    .dmem_ack(dmem_ack), .dmem_req(dmem_req),
    .fwda(fwda), .fwdb(fwdb), .pc_en(pc_en),
    .ifid_en(ifid_en), .idexe_en(idexe_en),
    .idexe_bubble(idexe_bubble), .exemem_en(exemem_en),
    .memwb_bubble(memwb_bubble), .mem_err(mem_err),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs, rt;
    logic       use_rs, use_rt;
    logic [4:0] ern;
    logic       ewreg, em2reg;
    logic [4:0] mrn;
    logic       mwreg, mm2reg, mwmem, ack;
  } stim_t;

  typedef struct {
    logic [1:0] fa, fb;
    logic [5:0] ctl;
    logic       req, err;
    int         cnt;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model: progress of the current memory access.
  bit m_busy = 0;
  bit m_done = 0;
  bit m_err  = 0;
  int m_req_cycles = 0;
  int m_cnt = 0;

  function automatic logic [1:0] ref_fwd(stim_t s, logic [4:0] r);
    if (s.ewreg && s.ern != 0 && s.ern == r && !s.em2reg)
      return 2'b01;
    if (s.mwreg && s.mrn != 0 && s.mrn == r)
      return s.mm2reg ? 2'b11 : 2'b10;
    return 2'b00;
  endfunction

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               n, act, exp, $time);
    end
  endtask

  task automatic step(input stim_t s);
    exp_t e;
    bit frz, lu, memop;
    @(negedge clk);
    rst = s.rst; rs = s.rs; rt = s.rt;
    use_rs = s.use_rs; use_rt = s.use_rt;
    ern = s.ern; ewreg = s.ewreg; em2reg = s.em2reg;
    mrn = s.mrn; mwreg = s.mwreg; mm2reg = s.mm2reg;
    mwmem = s.mwmem; dmem_ack = s.ack;
    e.err = m_err;
    e.cnt = m_cnt;
    if (s.rst) begin
      e.fa = 0; e.fb = 0; e.req = 0; e.ctl = 6'b000101;
      sb.push_back(e);
      m_busy = 0; m_done = 0; m_err = 0;
      m_req_cycles = 0; m_cnt = 0;
    end else begin
      memop = s.mm2reg | s.mwmem;
      frz = m_err || m_busy || (!m_done && memop);
      lu = s.ewreg && s.em2reg && s.ern != 0 &&
           ((s.use_rs && s.ern == s.rs) ||
            (s.use_rt && s.ern == s.rt));
      e.ctl = frz ? 6'b000001 : lu ? 6'b001110 : 6'b111010;
      e.fa = ref_fwd(s, s.rs);
      e.fb = ref_fwd(s, s.rt);
      e.req = m_busy;
      sb.push_back(e);
      if (!e.ctl[5] && m_cnt < CNT_MAX) m_cnt++;
      if (m_err) begin
      end else if (m_busy) begin
        m_req_cycles++;
        if (s.ack) begin
          m_busy = 0; m_done = 1;
        end else if (m_req_cycles == TIMEOUT) begin
          m_busy = 0; m_err = 1;
        end
      end else if (m_done) begin
        m_done = 0;
      end else if (memop) begin
        m_busy = 1; m_req_cycles = 0;
      end
    end
  endtask

  // Monitor: compare each presented cycle against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("fwda", fwda, e.fa);
        chk("fwdb", fwdb, e.fb);
        chk("ctl", {pc_en, ifid_en, idexe_en, idexe_bubble,
                    exemem_en, memwb_bubble}, e.ctl);
        chk("dmem_req", dmem_req, e.req);
        chk("mem_err", mem_err, e.err);
        chk("stall_cnt", stall_cnt, e.cnt);
      end
    end
  end

  initial begin
    stim_t s;
    repeat (2) @(posedge clk);
    s = '0; s.rst = 1; step(s);
    // no hazard
    s = '0; s.rs = 3; s.ern = 5; s.ewreg = 1;
    s.mrn = 7; s.mwreg = 1;
    repeat (2) step(s);
    // forward priority
    s = '0; s.rs = 4; s.rt = 4; s.ern = 4; s.ewreg = 1;
    s.mrn = 4; s.mwreg = 1;
    step(s);
    s.ewreg = 0; step(s);
    s.mm2reg = 0; s.mm2reg = 1; s.mwreg = 1; s.mrn = 4;
    s.ern = 4;
    // mm2reg makes this a mem op; finish its access with ack
    step(s);
    s.ack = 1; step(s);
    s.ack = 0; step(s);
    s = '0; s.rs = 0; s.ern = 0; s.ewreg = 1;
    s.mrn = 0; s.mwreg = 1; step(s);
    // load-use on rt
    s = '0; s.ern = 8; s.ewreg = 1; s.em2reg = 1;
    s.use_rt = 1; s.rt = 8; step(s);
    s = '0; step(s);
    // load in MEM, ack in third REQ cycle
    s = '0; s.mm2reg = 1; s.mwreg = 1; s.mrn = 9;
    repeat (3) step(s);
    s.ack = 1; step(s);
    s.ack = 0; step(s);
    // store then load back-to-back, immediate ack, lu masked
    s = '0; s.mwmem = 1; s.ern = 2; s.ewreg = 1; s.em2reg = 1;
    s.use_rs = 1; s.rs = 2;
    step(s); s.ack = 1; step(s); s.ack = 0; step(s);
    s.mwmem = 0; s.mm2reg = 1;
    step(s); s.ack = 1; step(s); s.ack = 0; step(s);
    // timeout into ERR, then reset out of it
    s = '0; s.mwmem = 1;
    repeat (7) step(s);
    s.rst = 1; step(s);
    s = '0; repeat (2) step(s);
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      s = '0;
      s.rst = ($urandom_range(0, 99) < 2) ||
              (m_err && $urandom_range(0, 7) == 0);
      s.rs = 5'($urandom_range(0, 3));
      s.rt = 5'($urandom_range(0, 3));
      s.use_rs = 1'($urandom);
      s.use_rt = 1'($urandom);
      s.ern = 5'($urandom_range(0, 3));
      s.ewreg = 1'($urandom);
      s.em2reg = 1'($urandom);
      s.mrn = 5'($urandom_range(0, 3));
      s.mwreg = 1'($urandom);
      s.mm2reg = $urandom_range(0, 99) < 15;
      s.mwmem = $urandom_range(0, 99) < 15;
      s.ack = $urandom_range(0, 99) < 45;
      step(s);
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard and stall controller for the 5-stage MIPS pipeline.
- Computes ID-stage forwarding selects.
- Detects load-use hazards and inserts bubbles.
- Sequences each data-memory access in the MEM stage through a req/ack handshake, freezing the pipeline until the access completes.
- Drives the hold/bubble controls of PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB, and keeps a stall-cycle counter.

Parameters:
TIMEOUT, 16, max REQ cycles waiting for dmem_ack before entering ERR (>=2)
CNT_W, 32, width of stall_cnt

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
rs  in  5  ID-stage rs field
rt  in  5  ID-stage rt field
use_rs  in  1  ID instruction reads rs
use_rt  in  1  ID instruction reads rt
ern  in  5  EXE destination register
ewreg  in  1  EXE writes register
em2reg  in  1  EXE is a load
mrn  in  5  MEM destination register
mwreg  in  1  MEM writes register
mm2reg  in  1  MEM is a load
mwmem  in  1  MEM is a store
dmem_ack  in  1  data memory completes access
dmem_req  out  1  data memory request
fwda  out  2  rs operand select: 00 regfile, 01 EXE alu, 10 MEM alu, 11 MEM load data
fwdb  out  2  rt operand select, same encoding as fwda
pc_en  out  1  PC update enable
ifid_en  out  1  IF/ID register enable
idexe_en  out  1  ID/EXE register enable
idexe_bubble  out  1  load zero control into ID/EXE
exemem_en  out  1  EXE/MEM register enable
memwb_bubble  out  1  load zero control into MEM/WB
mem_err  out  1  sticky timeout flag
stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0

Behaviour:
- Reset (rst=1 at posedge): state<=IDLE, wait_cnt<=0, mem_err<=0, stall_cnt<=0.
  - While rst=1: dmem_req=0, all *_en=0, idexe_bubble=1, memwb_bubble=1, fwda=fwdb=00.
  - Reset mid-access abandons the access; dmem_req is 0 from the reset edge.
- Forwarding (combinational, fwda shown; fwdb identical using rt):
  - 01 if ewreg & ern!=0 & ern==rs & !em2reg.
  - Else 10 if mwreg & mrn!=0 & mrn==rs & !mm2reg.
  - Else 11 if mwreg & mrn!=0 & mrn==rs & mm2reg.
  - Else 00.
  - EXE has priority over MEM. Register 0 never forwards.
- Load-use stall (lu):
  - lu = ewreg & em2reg & ern!=0 & ((use_rs & ern==rs) | (use_rt & ern==rt)).
- mem_op = mm2reg | mwmem.
- FSM states: IDLE, REQ, DONE, ERR.
  - IDLE: if mem_op, go to REQ and freeze this cycle; else stay in IDLE and run normally.
  - REQ: dmem_req=1, freeze. On dmem_ack, go to DONE and clear wait_cnt. Otherwise wait_cnt++; when wait_cnt==TIMEOUT-1 without ack, go to ERR and set mem_err.
  - DONE: dmem_req=0, pipeline advances this cycle (the MEM instruction moves to WB). Next state is IDLE. A mem_op arriving in MEM is handled from IDLE on the following cycle.
  - ERR: freeze permanently, dmem_req=0, mem_err=1; only rst exits.
  - dmem_ack outside REQ is ignored.
- Freeze: pc_en=ifid_en=idexe_en=exemem_en=0, idexe_bubble=0, memwb_bubble=1. Freeze takes priority over lu.
- Not frozen and lu: pc_en=ifid_en=0, idexe_en=1, idexe_bubble=1, exemem_en=1, memwb_bubble=0.
- Otherwise: all enables 1, both bubbles 0.
- Latency:
  - Memory op with ack in its first REQ cycle occupies MEM for 3 cycles (IDLE-freeze, REQ, DONE).
  - Each additional ack delay adds 1 cycle.
  - Load-use costs 1 bubble.
- stall_cnt increments on every non-reset cycle with pc_en=0 and saturates at all-ones.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - FSM state encoding (IDLE=0, REQ=1, DONE=2, ERR=3).
  - Forward-select constants FWD_RF/FWD_EALU/FWD_MALU/FWD_MMEM.
- One sub-module, fwd_unit: purely combinational forwarding logic, instantiated once per operand (rs, rt).
- FSM, stall logic and counters stay in the top module.

Test Plan:
1. No hazard: rs=3, ern=5, ewreg=1, mrn=7, mwreg=1 -> fwda=00; all enables 1; stall_cnt stays 0.
2. Forward priority: rs=4, ern=4 ewreg=1 em2reg=0, mrn=4 mwreg=1 -> fwda=01. Drop ewreg -> 10. Set mm2reg=1 -> 11. ern=mrn=0 -> 00.
3. Load-use: ern=8 ewreg=1 em2reg=1, use_rt=1 rt=8 -> one cycle with pc_en=0, ifid_en=0, idexe_bubble=1; stall_cnt=1.
4. Load in MEM, ack in 3rd REQ cycle -> dmem_req high exactly 3 cycles; freeze for 4 cycles total; DONE cycle has exemem_en=1 and memwb_bubble=0; stall_cnt=4.
5. Back-to-back store then load, ack immediate -> each access takes 3 cycles, no dmem_req glitch in DONE; load-use in the same cycles is masked by freeze.
6. TIMEOUT=4, no ack -> ERR after 4 REQ cycles; mem_err=1 and freeze held. Assert rst for 1 cycle during ERR -> IDLE, mem_err=0, stall_cnt=0, dmem_req=0.
